execute_stage_pipe: RTL and testbench
=====================================

Name: execute_stage_pipe

Overview:
- Parametrised, pipelined Y86-64 execute stage with registered outputs.
- Contains the full ALU (add/sub/and/xor), a persistent condition-code register (ZF/SF/OF) and jXX/cmovXX condition evaluation.
- Supports stall/bubble pipeline control and suppresses CC updates while a later stage holds an exception.
- Sits between the decode pipeline register and the memory stage. Latency is one cycle.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE; must be ≥ 8.
- STACK_STEP, 8, constant added or subtracted for call/ret/pushq/popq.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decode register holds a real instruction
- icode  input  4  instruction code
- ifun  input  4  function code
- valA  input  WIDTH  operand A
- valB  input  WIDTH  operand B
- valC  input  WIDTH  constant word
- dstE_in  input  4  destination register for valE
- stall  input  1  hold the output register
- bubble  input  1  inject a NOP into the output register
- cc_hold  input  1  exception in M/W; block CC writes
- out_valid  output  1  registered valid
- icode_out  output  4  registered icode
- valE  output  WIDTH  registered ALU result
- valA_out  output  WIDTH  registered valA pass-through
- dstE_out  output  4  registered destination; RNONE when a cmov is not taken
- cnd  output  1  registered condition result
- cc  output  3  current CC register {ZF,SF,OF}
- bad_op  output  1  registered flag: OPq with ifun>3, or jXX/cmovXX with ifun>6

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately): out_valid=0, icode_out=4'h1 (nop), valE=0, valA_out=0, dstE_out=RNONE, cnd=0, bad_op=0, cc=3'b100 (ZF=1). Reset asserted mid-operation discards the in-flight instruction and any pending CC update.
- Combinational ALU, with all arithmetic modulo 2^WIDTH:
  - OPq (6): add = valB+valA; sub = valB−valA; and = valB&valA; xor = valB^valA. For ifun>3: result 0 and bad_op=1.
  - rrmovq/cmovXX (2): valA+0.
  - irmovq (3): valC+0.
  - rmmovq (4) and mrmovq (5): valB+valC.
  - call (8) and pushq (A): valB−STACK_STEP.
  - ret (9) and popq (B): valB+STACK_STEP.
  - All other icodes: result 0.
- CC computation from the OPq result r:
  - ZF = (r==0); SF = r[WIDTH-1].
  - OF for add: sign(valA)==sign(valB) and sign(r)!=sign(valB).
  - OF for sub: sign(valA)!=sign(valB) and sign(r)!=sign(valB).
  - OF for and/xor: 0.
- CC write: at posedge only when in_valid & icode==6 & ifun≤3 & !stall & !bubble & !cc_hold. Otherwise cc holds its value.
- Condition evaluation for icode 2 or 7 uses the CC register value before any write in the same cycle:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
  - ifun >6: cnd=0 and bad_op=1.
  - All other icodes: cnd=0.
- dstE_out = RNONE when icode==2 and cnd==0; otherwise dstE_in.
- Output register priority at each posedge:
  - stall=1: all outputs hold their values; no CC write. stall takes precedence over bubble when both are asserted.
  - else bubble=1: load the reset/NOP values (cc unaffected).
  - else in_valid=0: load the NOP values.
  - else: load the computed values; out_valid=1.
- No internal state besides the output register and cc. Back-to-back instructions are accepted every cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → outputs go to their reset values immediately, cc=3'b100; release rst, then a valid irmovq with valC=0x10 → next cycle valE=0x10, out_valid=1.
- OPq add overflow: valA=valB=0x4000_0000_0000_0000 → valE=0x8000_0000_0000_0000, cc={0,1,1}. Then sub with valB=5, valA=5 → valE=0, cc={1,0,0}.
- Condition after a sub of valB=3, valA=7 (r=−4, cc={0,1,0}): jXX ifun 2 → cnd=1; ifun 6 → cnd=0; cmovXX ifun 3 with dstE_in=3 → cnd=0, dstE_out=4'hF.
- Stall/bubble: stall held for 2 cycles while valB changes → outputs frozen and cc unchanged; bubble → icode_out=1, out_valid=0; stall and bubble together → hold.
- cc_hold: OPq xor with valA=valB=0xFF and cc_hold=1 → valE=0, cc keeps its prior value. OPq with ifun=7 → bad_op=1, valE=0, cc unchanged.
- Stack ops with WIDTH=32: pushq with valB=0x100 → valE=0xF8; popq with valB=0xFFFF_FFFC → valE=0x4 (wrap-around).

Source files
------------

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe
//   Pipelined Y86-64 execute stage. The ALU, condition-code register and
//   jXX/cmovXX condition logic are combinational. Their results are captured
//   in a single output register, so the stage has a latency of one cycle.
//   A new instruction can be accepted on every cycle.
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   in_valid              the decode register holds a real instruction
//   icode, ifun           instruction and function codes
//   valA, valB, valC      operands and constant word
//   dstE_in               destination register for valE
//   stall                 hold the output register (also blocks CC writes)
//   bubble                load a NOP into the output register
//   cc_hold               a later stage holds an exception; block CC writes
//   out_valid, icode_out  registered valid flag and icode
//   valE, valA_out        registered ALU result and valA pass-through
//   dstE_out              registered destination (RNONE for an untaken cmov)
//   cnd                   registered condition result
//   cc                    condition-code register {ZF,SF,OF}
//   bad_op                registered illegal-function flag

module execute_stage_pipe #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = 8,
    parameter logic [3:0]  RNONE      = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic [3:0]       dstE_in,
    input  logic             stall,
    input  logic             bubble,
    input  logic             cc_hold,
    output logic             out_valid,
    output logic [3:0]       icode_out,
    output logic [WIDTH-1:0] valE,
    output logic [WIDTH-1:0] valA_out,
    output logic [3:0]       dstE_out,
    output logic             cnd,
    output logic [2:0]       cc,
    output logic             bad_op
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [WIDTH-1:0] STEP   = WIDTH'(STACK_STEP);
    localparam logic [2:0]       CC_RST = 3'b100;

    // ---------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------
    logic             valid_q,  valid_d;
    logic [3:0]       icode_q,  icode_d;
    logic [WIDTH-1:0] vale_q,   vale_d;
    logic [WIDTH-1:0] vala_q,   vala_d;
    logic [3:0]       dste_q,   dste_d;
    logic             cnd_q,    cnd_d;
    logic             bad_q,    bad_d;
    logic [2:0]       cc_q,     cc_d;

    // ---------------------------------------------------------------
    // ALU
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             op_bad;

    always_comb begin
        alu_res = '0;
        op_bad  = 1'b0;
        case (icode)
            I_OPQ: begin
                case (ifun)
                    ALU_ADD: alu_res = valB + valA;
                    ALU_SUB: alu_res = valB - valA;
                    ALU_AND: alu_res = valB & valA;
                    ALU_XOR: alu_res = valB ^ valA;
                    default: begin
                        alu_res = '0;
                        op_bad  = 1'b1;
                    end
                endcase
            end
            I_RRMOV:        alu_res = valA;
            I_IRMOV:        alu_res = valC;
            I_RMMOV,
            I_MRMOV:        alu_res = valB + valC;
            I_CALL, I_PUSH: alu_res = valB - STEP;
            I_RET,  I_POP:  alu_res = valB + STEP;
            default:        alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // Condition codes produced by an OPq
    // ---------------------------------------------------------------
    logic sign_a, sign_b, sign_r;
    logic of_calc;
    logic [2:0] cc_calc;
    logic cc_we;

    assign sign_a = valA[WIDTH-1];
    assign sign_b = valB[WIDTH-1];
    assign sign_r = alu_res[WIDTH-1];

    always_comb begin
        of_calc = 1'b0;
        case (ifun)
            ALU_ADD: of_calc = (sign_a == sign_b) && (sign_r != sign_b);
            ALU_SUB: of_calc = (sign_a != sign_b) && (sign_r != sign_b);
            default: of_calc = 1'b0;
        endcase
    end

    assign cc_calc = {(alu_res == '0), sign_r, of_calc};

    // Stall and bubble both kill the CC write, as does an exception further
    // down the pipe, so a squashed OPq never leaves flags behind.
    assign cc_we = in_valid && (icode == I_OPQ) && (ifun <= ALU_XOR) &&
                   !stall && !bubble && !cc_hold;

    // ---------------------------------------------------------------
    // jXX / cmovXX condition, evaluated against the flags as they stand
    // before any write in this cycle
    // ---------------------------------------------------------------
    logic zf, sf, of;
    logic cond_res;
    logic cond_bad;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        cond_res = 1'b0;
        cond_bad = 1'b0;
        if ((icode == I_RRMOV) || (icode == I_JXX)) begin
            case (ifun)
                4'h0:    cond_res = 1'b1;
                4'h1:    cond_res = (sf ^ of) | zf;
                4'h2:    cond_res = sf ^ of;
                4'h3:    cond_res = zf;
                4'h4:    cond_res = !zf;
                4'h5:    cond_res = !(sf ^ of);
                4'h6:    cond_res = !(sf ^ of) && !zf;
                default: begin
                    cond_res = 1'b0;
                    cond_bad = 1'b1;
                end
            endcase
        end
    end

    // An untaken cmov must not write its destination register.
    logic [3:0] dst_calc;
    assign dst_calc = ((icode == I_RRMOV) && !cond_res) ? RNONE : dstE_in;

    // ---------------------------------------------------------------
    // Output register next-state: stall > bubble > idle > load
    // ---------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        icode_d = icode_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        dste_d  = dste_q;
        cnd_d   = cnd_q;
        bad_d   = bad_q;
        if (stall) begin
            // hold everything
        end else if (bubble || !in_valid) begin
            valid_d = 1'b0;
            icode_d = I_NOP;
            vale_d  = '0;
            vala_d  = '0;
            dste_d  = RNONE;
            cnd_d   = 1'b0;
            bad_d   = 1'b0;
        end else begin
            valid_d = 1'b1;
            icode_d = icode;
            vale_d  = alu_res;
            vala_d  = valA;
            dste_d  = dst_calc;
            cnd_d   = cond_res;
            bad_d   = op_bad | cond_bad;
        end
    end

    assign cc_d = cc_we ? cc_calc : cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            icode_q <= I_NOP;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= RNONE;
            cnd_q   <= 1'b0;
            bad_q   <= 1'b0;
            cc_q    <= CC_RST;
        end else begin
            valid_q <= valid_d;
            icode_q <= icode_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            cnd_q   <= cnd_d;
            bad_q   <= bad_d;
            cc_q    <= cc_d;
        end
    end

    assign out_valid = valid_q;
    assign icode_out = icode_q;
    assign valE      = vale_q;
    assign valA_out  = vala_q;
    assign dstE_out  = dste_q;
    assign cnd       = cnd_q;
    assign bad_op    = bad_q;
    assign cc        = cc_q;

    // halt has no ALU work; named here so the decode table stays complete
    logic unused_halt;
    assign unused_halt = (icode == I_HALT);

endmodule

// File: tb/tb_execute_stage_pipe.sv
module tb_execute_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  icode = 4'h1, ifun = 4'h0;
    logic [63:0] valA = '0, valB = '0, valC = '0;
    logic [3:0]  dstE_in = 4'hF;
    logic        stall = 1'b0, bubble = 1'b0, cc_hold = 1'b0;

    logic        out_valid, cnd, bad_op;
    logic [3:0]  icode_out, dstE_out;
    logic [63:0] valE, valA_out;
    logic [2:0]  cc;

    logic        ov32, cnd32, bad32;
    logic [3:0]  ic32, dst32;
    logic [31:0] vale32, vala32;
    logic [2:0]  cc32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_stage_pipe #(.WIDTH(64), .STACK_STEP(8), .RNONE(4'hF)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC), .dstE_in(dstE_in),
        .stall(stall), .bubble(bubble), .cc_hold(cc_hold),
        .out_valid(out_valid), .icode_out(icode_out), .valE(valE),
        .valA_out(valA_out), .dstE_out(dstE_out), .cnd(cnd), .cc(cc),
        .bad_op(bad_op)
    );

    execute_stage_pipe #(.WIDTH(32), .STACK_STEP(8), .RNONE(4'hF)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .valA(valA[31:0]), .valB(valB[31:0]), .valC(valC[31:0]), .dstE_in(dstE_in),
        .stall(stall), .bubble(bubble), .cc_hold(cc_hold),
        .out_valid(ov32), .icode_out(ic32), .valE(vale32),
        .valA_out(vala32), .dstE_out(dst32), .cnd(cnd32), .cc(cc32),
        .bad_op(bad32)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c;
        logic [3:0]  dst;
        logic        bb, ch;
        logic        e_ov;
        logic [3:0]  e_ic;
        logic [63:0] e_vale, e_vala;
        logic [3:0]  e_dst;
        logic        e_cnd;
        logic [2:0]  e_cc;
        logic        e_bad;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mv(
        logic iv, logic [3:0] ic, logic [3:0] fn,
        logic [63:0] a, logic [63:0] b, logic [63:0] c, logic [3:0] dst,
        logic bb, logic ch,
        logic e_ov, logic [3:0] e_ic, logic [63:0] e_vale, logic [63:0] e_vala,
        logic [3:0] e_dst, logic e_cnd, logic [2:0] e_cc, logic e_bad);
        vec_t v;
        v.iv = iv; v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c; v.dst = dst;
        v.bb = bb; v.ch = ch;
        v.e_ov = e_ov; v.e_ic = e_ic; v.e_vale = e_vale; v.e_vala = e_vala;
        v.e_dst = e_dst; v.e_cnd = e_cnd; v.e_cc = e_cc; v.e_bad = e_bad;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] dst);
        in_valid = iv; icode = ic; ifun = fn;
        valA = a; valB = b; valC = c; dstE_in = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] H4 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] H8 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] M4 = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

    initial begin
        // iv ic fn a b c dst bb ch | ov ic valE valA dst cnd cc bad
        vt.push_back(mv(1,3,0, 0,    0,     64'h10, 2, 0,0, 1,3, 64'h10, 0,    2, 0,3'b100,0));
        vt.push_back(mv(1,6,0, H4,   H4,    0,      3, 0,0, 1,6, H8,     H4,   3, 0,3'b011,0));
        vt.push_back(mv(1,7,2, 0,    0,     64'h40, 15,0,0, 1,7, 0,      0,   15, 0,3'b011,0));
        vt.push_back(mv(1,6,1, 5,    5,     0,      4, 0,0, 1,6, 0,      5,    4, 0,3'b100,0));
        vt.push_back(mv(1,7,3, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 1,3'b100,0));
        vt.push_back(mv(1,6,1, 7,    3,     0,      5, 0,0, 1,6, M4,     7,    5, 0,3'b010,0));
        vt.push_back(mv(1,7,2, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 1,3'b010,0));
        vt.push_back(mv(1,7,6, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 0,3'b010,0));
        vt.push_back(mv(1,2,3, 64'h55,0,    0,      3, 0,0, 1,2, 64'h55, 64'h55,15,0,3'b010,0));
        vt.push_back(mv(1,2,1, 64'h66,0,    0,      3, 0,0, 1,2, 64'h66, 64'h66,3, 1,3'b010,0));
        vt.push_back(mv(1,7,7, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 0,3'b010,1));
        vt.push_back(mv(1,6,7, 1,    2,     0,      6, 0,0, 1,6, 0,      1,    6, 0,3'b010,1));
        vt.push_back(mv(1,6,3, 64'hFF,64'hFF,0,     7, 0,1, 1,6, 0,      64'hFF,7, 0,3'b010,0));
        vt.push_back(mv(1,6,2, 64'hF0,64'h0F,0,     7, 0,0, 1,6, 0,      64'hF0,7, 0,3'b100,0));
        vt.push_back(mv(1,4,0, 64'h11,64'h100,64'h20,15,0,0,1,4, 64'h120,64'h11,15,0,3'b100,0));
        vt.push_back(mv(1,5,0, 0,    8,     M8,     15,0,0, 1,5, 0,      0,   15, 0,3'b100,0));
        vt.push_back(mv(1,8,0, 0,    64'h100,0,     4, 0,0, 1,8, 64'hF8, 0,    4, 0,3'b100,0));
        vt.push_back(mv(1,9,0, 0,    64'hF8,0,      4, 0,0, 1,9, 64'h100,0,    4, 0,3'b100,0));
        vt.push_back(mv(0,6,0, 1,    1,     0,      2, 0,0, 0,1, 0,      0,   15, 0,3'b100,0));
        vt.push_back(mv(1,6,0, 2,    3,     0,      2, 0,0, 1,6, 5,      2,    2, 0,3'b000,0));
        vt.push_back(mv(1,7,4, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 1,3'b000,0));
        vt.push_back(mv(1,2,5, 64'h77,0,    0,      6, 0,0, 1,2, 64'h77, 64'h77,6, 1,3'b000,0));
        vt.push_back(mv(1,6,1, 1,    1,     0,      2, 1,0, 0,1, 0,      0,   15, 0,3'b000,0));
        vt.push_back(mv(1,10,0,9,    64'h100,0,     4, 0,0, 1,10,64'hF8, 9,    4, 0,3'b000,0));
        vt.push_back(mv(1,11,0,0,    M4,    0,      4, 0,0, 1,11,4,      0,    4, 0,3'b000,0));
        vt.push_back(mv(1,6,1, 1,    H8,    0,      3, 0,0, 1,6, 64'h7FFF_FFFF_FFFF_FFFF,1,3,0,3'b001,0));
        vt.push_back(mv(1,7,1, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 1,3'b001,0));
        vt.push_back(mv(1,0,0, 5,    0,     0,      15,0,0, 1,0, 0,      5,   15, 0,3'b001,0));
        vt.push_back(mv(1,7,0, 0,    0,     0,      15,0,0, 1,7, 0,      0,   15, 1,3'b001,0));

        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_icode", icode_out, 4'h1);
        chk("rst_valE",  valE, 0);
        chk("rst_valA",  valA_out, 0);
        chk("rst_dstE",  dstE_out, 4'hF);
        chk("rst_cnd",   cnd, 0);
        chk("rst_bad",   bad_op, 0);
        chk("rst_cc",    cc, 3'b100);
        #9 rst = 1'b0;
        step();

        foreach (vt[i]) begin
            drive(vt[i].iv, vt[i].ic, vt[i].fn, vt[i].a, vt[i].b, vt[i].c, vt[i].dst);
            bubble = vt[i].bb; cc_hold = vt[i].ch; stall = 1'b0;
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("v%0d_icode", i), icode_out, vt[i].e_ic);
            chk($sformatf("v%0d_valE",  i), valE,      vt[i].e_vale);
            chk($sformatf("v%0d_valA",  i), valA_out,  vt[i].e_vala);
            chk($sformatf("v%0d_dstE",  i), dstE_out,  vt[i].e_dst);
            chk($sformatf("v%0d_cnd",   i), cnd,       vt[i].e_cnd);
            chk($sformatf("v%0d_cc",    i), cc,        vt[i].e_cc);
            chk($sformatf("v%0d_bad",   i), bad_op,    vt[i].e_bad);
        end
        bubble = 1'b0; cc_hold = 1'b0;

        // stall freezes outputs and cc; stall beats bubble; then bubble
        drive(1, 6, 0, 2, 3, 0, 2);
        step();
        chk("stl_pre_valE", valE, 5);
        chk("stl_pre_cc", cc, 3'b000);
        drive(1, 6, 1, 10, 10, 0, 3);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valB = (k == 0) ? 64'd10 : 64'd20;
            step();
            chk($sformatf("stl%0d_valE", k), valE, 5);
            chk($sformatf("stl%0d_valA", k), valA_out, 2);
            chk($sformatf("stl%0d_icode", k), icode_out, 4'h6);
            chk($sformatf("stl%0d_cc", k), cc, 3'b000);
            chk($sformatf("stl%0d_valid", k), out_valid, 1);
        end
        bubble = 1'b1;
        step();
        chk("stlbub_valid", out_valid, 1);
        chk("stlbub_valE", valE, 5);
        chk("stlbub_cc", cc, 3'b000);
        stall = 1'b0;
        step();
        chk("bub_valid", out_valid, 0);
        chk("bub_icode", icode_out, 4'h1);
        chk("bub_dstE", dstE_out, 4'hF);
        chk("bub_cc", cc, 3'b000);
        bubble = 1'b0;

        // reset mid-cycle discards an in-flight instruction and its CC update
        drive(1, 6, 0, 1, 1, 0, 2);
        step();
        chk("prerst_valE", valE, 2);
        drive(1, 6, 0, H4, H4, 0, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_valE", valE, 0);
        chk("midrst_icode", icode_out, 4'h1);
        step();
        chk("holdrst_cc", cc, 3'b100);
        chk("holdrst_valid", out_valid, 0);
        rst = 1'b0;
        drive(1, 3, 0, 0, 0, 64'h10, 2);
        step();
        chk("postrst_valE", valE, 64'h10);
        chk("postrst_valid", out_valid, 1);
        chk("postrst_cc", cc, 3'b100);

        // stack pointer arithmetic on the 32-bit instance
        drive(1, 10, 0, 0, 64'h100, 0, 4);
        step();
        chk("w32_push_valE", vale32, 32'hF8);
        drive(1, 11, 0, 0, 64'h0000_0000_FFFF_FFFC, 0, 4);
        step();
        chk("w32_pop_valE", vale32, 32'h4);
        chk("w64_pop_valE", valE, 64'h1_0000_0004);
        chk("w32_pop_valid", ov32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
